gpio_ctrl: RTL
==============

Name: gpio_ctrl

Overview:
- Parametrised memory-mapped GPIO controller for the RV32I SoC.
- Replaces the fixed 16-bit enable/out/in wiring with software-visible registers:
  - per-bit direction
  - atomic set/clear/toggle
  - input synchroniser
  - per-bit rising/falling-edge interrupts with a sticky pending register
- Sits on the core's peripheral bus. Pin tristating (en ? out : z) stays in the board-level wrapper.

Parameters:
- WIDTH, 16, number of GPIO pins, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, ≥2.
- ADDR_W, 6, byte-address bits decoded (register window 64 B).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- bus_req  in  1  access strobe, single cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- bus_wdata  in  32  write data.
- bus_wstrb  in  4  byte-lane enables for writes.
- bus_rdata  out  32  read data, valid while bus_ready.
- bus_ready  out  1  response strobe, one cycle after bus_req.
- gpio_in  in  WIDTH  raw asynchronous pin levels.
- gpio_out  out  WIDTH  output data register.
- gpio_en  out  WIDTH  output enables (1 = drive).
- irq  out  1  level interrupt = |(PEND).

Behaviour:
- Register map (word offsets). Bits ≥ WIDTH read 0 and ignore writes.
  - 0x00 IN: RO, synchronised pin levels.
  - 0x04 OUT: RW.
  - 0x08 DIR: RW.
  - 0x0C SET: WO, OUT |= wdata.
  - 0x10 CLR: WO, OUT &= ~wdata.
  - 0x14 TGL: WO, OUT ^= wdata.
  - 0x18 RISE_EN: RW.
  - 0x1C FALL_EN: RW.
  - 0x20 PEND: RW1C.
  - Other offsets: read 0, writes ignored.
  - WO registers read 0.
- Byte lanes: a write affects only bits in lanes with wstrb set; unstrobed bits are treated as wdata = 0 for SET/CLR/TGL/PEND.
- Bus timing:
  - bus_req in cycle N → bus_ready = 1 in N+1 only; rdata registered in N+1; rdata = 0 on writes.
  - Write side effects are visible on gpio_out/gpio_en in N+1.
  - A bus_req asserted in N+1 is accepted independently (back-to-back, full throughput).
- Input path:
  - gpio_in passes through SYNC_STAGES flops to give sync.
  - prev holds sync delayed one cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - IN reads sync.
- Pending update per bit:
  - next = (PEND & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - A new edge in the same cycle as a W1C of that bit wins: the bit stays 1.
- Edges are detected regardless of DIR, so output pins looped back also generate events.
- Warm-up:
  - A counter of SYNC_STAGES+1 cycles after rst deasserts suppresses edge capture.
  - This prevents spurious edges from the 0-initialised chain.
  - Bus access is accepted during warm-up.
- Reset values:
  - OUT, DIR, RISE_EN, FALL_EN, PEND, sync chain, prev = 0.
  - bus_ready = 0, bus_rdata = 0, irq = 0.
  - Warm-up counter restarts.
- Reset mid-transaction: an access in the cycle rst is high is dropped; no bus_ready follows.
- irq is registered from PEND, so it rises one cycle after PEND sets.

Decomposition:
- Package gpio_pkg:
  - register offset localparams (GPIO_IN … GPIO_PEND)
  - enum of decoded register selects
  - function applying wstrb to a 32-bit mask
- Sub-module gpio_sync: WIDTH-wide SYNC_STAGES synchroniser plus prev register, outputs sync/rise/fall.
- The remainder (decode, registers, warm-up) lives in gpio_ctrl.

Test Plan:
- Reset, then write DIR=0x00FF, OUT=0x1234 → gpio_en=0x00FF, gpio_out=0x1234 the cycle after bus_ready; reads return the same values.
- OUT=0x00F0:
  - SET 0x000F → 0x00FF
  - CLR 0x0030 → 0x00CF
  - TGL 0xFFFF → 0xFF30
- Write OUT=0xFFFFFFFF with wstrb=4'b0001 from OUT=0 → OUT=0x00FF; read of offset 0x24 → 0.
- RISE_EN=0x0001. Drive gpio_in[0] 0→1 → PEND[0]=1 SYNC_STAGES+1 cycles after the change, irq one cycle later. Write PEND=1 → PEND=0, irq drops. Falling edge with FALL_EN=0 → no pend.
- Hold gpio_in=0xFFFF through reset with RISE_EN written to 0xFFFF during warm-up → PEND stays 0.
- Time a W1C of PEND[3] in the same cycle as a new fall edge on bit 3 (FALL_EN[3]=1) → PEND[3] remains 1, irq stays high.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO controller.
//   - byte offsets of the software-visible registers
//   - enum of decoded register selects
//   - strb_mask(): expands a 4-bit byte-lane strobe to a 32-bit bit mask
//   - decode_sel(): maps a word-aligned byte address to a register select
package gpio_pkg;

  localparam logic [31:0] GPIO_IN      = 32'h00;
  localparam logic [31:0] GPIO_OUT     = 32'h04;
  localparam logic [31:0] GPIO_DIR     = 32'h08;
  localparam logic [31:0] GPIO_SET     = 32'h0C;
  localparam logic [31:0] GPIO_CLR     = 32'h10;
  localparam logic [31:0] GPIO_TGL     = 32'h14;
  localparam logic [31:0] GPIO_RISE_EN = 32'h18;
  localparam logic [31:0] GPIO_FALL_EN = 32'h1C;
  localparam logic [31:0] GPIO_PEND    = 32'h20;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_DIR,
    SEL_SET,
    SEL_CLR,
    SEL_TGL,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_PEND
  } reg_sel_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  function automatic reg_sel_e decode_sel(input logic [31:0] byte_addr);
    reg_sel_e sel;
    case (byte_addr)
      GPIO_IN:      sel = SEL_IN;
      GPIO_OUT:     sel = SEL_OUT;
      GPIO_DIR:     sel = SEL_DIR;
      GPIO_SET:     sel = SEL_SET;
      GPIO_CLR:     sel = SEL_CLR;
      GPIO_TGL:     sel = SEL_TGL;
      GPIO_RISE_EN: sel = SEL_RISE_EN;
      GPIO_FALL_EN: sel = SEL_FALL_EN;
      GPIO_PEND:    sel = SEL_PEND;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage input synchroniser with edge detection.
//   clk, rst  : system clock, synchronous active-high reset
//   gpio_i    : raw asynchronous pin levels
//   sync_o    : synchronised levels (last synchroniser stage)
//   rise_o    : sync & ~prev, one cycle per 0->1 transition
//   fall_o    : ~sync & prev, one cycle per 1->0 transition
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    assign rise_o[gi] =  sync_o[gi] & ~prev_q[gi];
    assign fall_o[gi] = ~sync_o[gi] &  prev_q[gi];
  end

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller for the peripheral bus.
//   clk, rst               : system clock, synchronous active-high reset
//   bus_req/we/addr/wdata/wstrb : single-cycle access strobe and payload
//   bus_rdata, bus_ready   : registered response, one cycle after bus_req
//   gpio_in                : raw asynchronous pin levels
//   gpio_out, gpio_en      : output data and output enables (tristate is external)
//   irq                    : registered OR of the pending register
// Registers: IN, OUT, DIR, SET/CLR/TGL (write-only), RISE_EN, FALL_EN, PEND (W1C).
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_en,
  output logic              irq
);

  // Edge capture stays off until the synchroniser and prev register have
  // been refilled from real pin levels after reset.
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q;
  logic             irq_q;
  logic [CNT_W-1:0] warm_cnt_q;
  logic             warm_done;

  logic [WIDTH-1:0] sync_lvl, rise, fall;
  logic [WIDTH-1:0] w1c, events;
  logic [31:0]      byte_addr;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask, wbits;
  logic             wr_en, rd_en;
  reg_sel_e         sel;
  logic             unused_bits;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .gpio_i(gpio_in),
    .sync_o(sync_lvl),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Address bits [1:0] are ignored: registers are word-wide.
  assign byte_addr = 32'({bus_addr[ADDR_W-1:2], 2'b00});
  assign sel       = decode_sel(byte_addr);
  assign wr_en     = bus_req & bus_we;
  assign rd_en     = bus_req & ~bus_we;

  // Unstrobed lanes behave as wdata = 0 for SET/CLR/TGL/PEND and keep
  // their old value for plain RW registers.
  assign lane_mask = strb_mask(bus_wstrb);
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wbits     = bus_wdata[WIDTH-1:0] & wmask;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata, lane_mask};

  assign warm_done = (warm_cnt_q == CNT_W'(WARM_CYCLES));

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (sel)
        SEL_OUT:     out_d     = (out_q & ~wmask) | wbits;
        SEL_DIR:     dir_d     = (dir_q & ~wmask) | wbits;
        SEL_SET:     out_d     = out_q | wbits;
        SEL_CLR:     out_d     = out_q & ~wbits;
        SEL_TGL:     out_d     = out_q ^ wbits;
        SEL_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wbits;
        SEL_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wbits;
        SEL_PEND:    w1c       = wbits;
        default:     ;
      endcase
    end
  end

  // A fresh edge is OR-ed in after the clear, so it survives a
  // simultaneous W1C of the same bit.
  assign events = warm_done ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
  assign pend_d = (pend_q & ~w1c) | events;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (sel)
        SEL_IN:      rdata_d = 32'(sync_lvl);
        SEL_OUT:     rdata_d = 32'(out_q);
        SEL_DIR:     rdata_d = 32'(dir_q);
        SEL_RISE_EN: rdata_d = 32'(rise_en_q);
        SEL_FALL_EN: rdata_d = 32'(fall_en_q);
        SEL_PEND:    rdata_d = 32'(pend_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
      warm_cnt_q <= '0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      ready_q    <= bus_req;
      irq_q      <= |pend_q;
      if (!warm_done) begin
        warm_cnt_q <= warm_cnt_q + 1'b1;
      end
    end
  end

  assign gpio_out  = out_q;
  assign gpio_en   = dir_q;
  assign irq       = irq_q;
  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;

endmodule
